// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    // Which control case wins this cycle, highest priority first in the encoding order below.
    typedef enum logic [1:0] {
        CTL_NONE,
        CTL_MEM,
        CTL_BRANCH,
        CTL_HAZARD
    } ctl_case_t;

    localparam logic [3:0]  REG_PC          = 4'd15;
    localparam int unsigned MEM_TIMEOUT_DEF = 64;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: RAW hazards, taken branches and multi-cycle
// SRAM waits merged into per-stage freeze/flush controls, plus a wait watchdog.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [3:0]       id_src_1,
    input  logic [3:0]       id_src_2,
    input  logic             id_two_src,
    input  logic             id_uses_src_1,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if_reg_freeze,
    output logic             if_reg_flush,
    output logic             id_reg_freeze,
    output logic             id_reg_flush,
    output logic             exe_reg_freeze,
    output logic             mem_reg_freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [15:0] TIMER_LAST = 16'(MEM_TIMEOUT - 1);

    mem_state_t  state;
    logic [15:0] timer;
    logic        mem_stall;
    logic        hit_exe_1, hit_mem_1, hit_exe_2, hit_mem_2;
    logic        m1, m2, load_use, hazard;
    ctl_case_t   ctl;

    assign hit_exe_1 = exe_wb_en & (id_src_1 == exe_dest);
    assign hit_mem_1 = mem_wb_en & (id_src_1 == mem_dest);
    assign hit_exe_2 = exe_wb_en & (id_src_2 == exe_dest);
    assign hit_mem_2 = mem_wb_en & (id_src_2 == mem_dest);

    assign m1 = id_uses_src_1 & (hit_exe_1 | hit_mem_1);
    assign m2 = id_two_src & (hit_exe_2 | hit_mem_2);

    // With forwarding, only a load in EXE can't be bypassed in time.
    assign load_use = exe_mem_r_en & ((id_uses_src_1 & hit_exe_1) | (id_two_src & hit_exe_2));
    assign hazard   = fwd_en ? load_use : (m1 | m2);

    assign mem_stall = (state == MEM_WAIT) | (mem_req & ~mem_ready);

    always_comb begin
        ctl = CTL_NONE;
        if (rst)               ctl = CTL_NONE;
        else if (mem_stall)    ctl = CTL_MEM;
        else if (branch_taken) ctl = CTL_BRANCH;
        else if (hazard)       ctl = CTL_HAZARD;
    end

    always_comb begin
        pc_freeze      = 1'b0;
        if_reg_freeze  = 1'b0;
        if_reg_flush   = 1'b0;
        id_reg_freeze  = 1'b0;
        id_reg_flush   = 1'b0;
        exe_reg_freeze = 1'b0;
        mem_reg_freeze = 1'b0;
        case (ctl)
            CTL_MEM: begin
                pc_freeze      = 1'b1;
                if_reg_freeze  = 1'b1;
                id_reg_freeze  = 1'b1;
                exe_reg_freeze = 1'b1;
                mem_reg_freeze = 1'b1;
            end
            CTL_BRANCH: begin
                if_reg_flush = 1'b1;
                id_reg_flush = 1'b1;
            end
            CTL_HAZARD: begin
                pc_freeze     = 1'b1;
                if_reg_freeze = 1'b1;
                id_reg_flush  = 1'b1;
            end
            default: ;
        endcase
    end

    // Timer parks at its last value once mem_err is set; the flag is sticky anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            timer   <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    timer <= '0;
                    if (mem_req && !mem_ready) state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (!mem_req || mem_ready) begin
                        state <= RUN;
                        timer <= '0;
                    end else if (timer == TIMER_LAST) begin
                        mem_err <= 1'b1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctl == CTL_HAZARD),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mem_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctl == CTL_MEM),
        .count (mem_wait_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctl == CTL_BRANCH),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a short watchdog and 4-bit counters.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       fwd_en, id_two_src, id_uses_src_1;
    logic [3:0] id_src_1, id_src_2, exe_dest, mem_dest;
    logic       exe_wb_en, exe_mem_r_en, mem_wb_en, branch_taken, mem_req, mem_ready;
    logic       pc_freeze, if_reg_freeze, if_reg_flush, id_reg_freeze, id_reg_flush;
    logic       exe_reg_freeze, mem_reg_freeze, mem_err;
    logic [3:0] stall_cnt, mem_wait_cnt, flush_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // {pc_frz, if_frz, if_flush, id_frz, id_flush, exe_frz, mem_frz}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_MEM  = 7'b1101011;
    localparam logic [6:0] C_BR   = 7'b0010100;
    localparam logic [6:0] C_HAZ  = 7'b1100100;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .fwd_en         (fwd_en),
        .id_src_1       (id_src_1),
        .id_src_2       (id_src_2),
        .id_two_src     (id_two_src),
        .id_uses_src_1  (id_uses_src_1),
        .exe_dest       (exe_dest),
        .exe_wb_en      (exe_wb_en),
        .exe_mem_r_en   (exe_mem_r_en),
        .mem_dest       (mem_dest),
        .mem_wb_en      (mem_wb_en),
        .branch_taken   (branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_freeze      (pc_freeze),
        .if_reg_freeze  (if_reg_freeze),
        .if_reg_flush   (if_reg_flush),
        .id_reg_freeze  (id_reg_freeze),
        .id_reg_flush   (id_reg_flush),
        .exe_reg_freeze (exe_reg_freeze),
        .mem_reg_freeze (mem_reg_freeze),
        .mem_err        (mem_err),
        .stall_cnt      (stall_cnt),
        .mem_wait_cnt   (mem_wait_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctl_bus();
        return {pc_freeze, if_reg_freeze, if_reg_flush, id_reg_freeze,
                id_reg_flush, exe_reg_freeze, mem_reg_freeze};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fwd_en = 0; id_src_1 = 0; id_src_2 = 0; id_two_src = 0; id_uses_src_1 = 0;
        exe_dest = 4'd9; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 4'd10; mem_wb_en = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("reset_ctl", 32'(ctl_bus()), 32'(C_NONE));
        chk("reset_err", 32'(mem_err), 0);
        chk("reset_cnts", {20'd0, stall_cnt, mem_wait_cnt, flush_cnt}, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("idle_ctl", 32'(ctl_bus()), 32'(C_NONE));

        // ADD R1 in EXE, ID reads R1, no forwarding
        exe_dest = 4'd1; exe_wb_en = 1; id_src_1 = 4'd1; id_uses_src_1 = 1;
        #1;
        chk("raw_exe_nofwd_ctl", 32'(ctl_bus()), 32'(C_HAZ));
        tick();
        chk("raw_exe_stall_cnt", 32'(stall_cnt), 1);
        fwd_en = 1;
        #1;
        chk("raw_exe_fwd_ctl", 32'(ctl_bus()), 32'(C_NONE));
        tick();
        chk("raw_exe_fwd_cnt", 32'(stall_cnt), 1);

        // Producer in MEM instead, no forwarding
        fwd_en = 0; exe_wb_en = 0; mem_dest = 4'd1; mem_wb_en = 1;
        #1;
        chk("raw_mem_nofwd_ctl", 32'(ctl_bus()), 32'(C_HAZ));
        tick();
        chk("raw_mem_stall_cnt", 32'(stall_cnt), 2);
        id_uses_src_1 = 0;
        #1;
        chk("mov_no_src_ctl", 32'(ctl_bus()), 32'(C_NONE));
        tick();

        // LDR R2 in EXE, STR in ID reads R2 as second source
        idle_inputs();
        fwd_en = 1; exe_dest = 4'd2; exe_wb_en = 1; exe_mem_r_en = 1;
        id_src_1 = 4'd5; id_uses_src_1 = 1; id_src_2 = 4'd2; id_two_src = 1;
        #1;
        chk("load_use_ctl", 32'(ctl_bus()), 32'(C_HAZ));
        tick();
        chk("load_use_cnt", 32'(stall_cnt), 3);
        id_two_src = 0;
        #1;
        chk("load_use_no_src2_ctl", 32'(ctl_bus()), 32'(C_NONE));
        tick();
        chk("load_use_no_src2_cnt", 32'(stall_cnt), 3);

        // Taken branch overrides a pending load-use hazard
        id_two_src = 1; branch_taken = 1;
        #1;
        chk("branch_ctl", 32'(ctl_bus()), 32'(C_BR));
        tick();
        chk("branch_flush_cnt", 32'(flush_cnt), 1);
        chk("branch_stall_cnt", 32'(stall_cnt), 3);

        // Multi-cycle SRAM access: 5 cycles not ready, then ready
        idle_inputs();
        mem_req = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("mem_wait_ctl_%0d", i), 32'(ctl_bus()), 32'(C_MEM));
            tick();
        end
        mem_ready = 1;
        #1;
        chk("mem_ready_cycle_ctl", 32'(ctl_bus()), 32'(C_MEM));
        tick();
        mem_req = 0; mem_ready = 0;
        #1;
        chk("mem_done_ctl", 32'(ctl_bus()), 32'(C_NONE));
        chk("mem_wait_cnt_6", 32'(mem_wait_cnt), 6);

        // Zero-wait access
        mem_req = 1; mem_ready = 1;
        #1;
        chk("zero_wait_ctl", 32'(ctl_bus()), 32'(C_NONE));
        tick();
        chk("zero_wait_cnt", 32'(mem_wait_cnt), 6);

        // mem_req dropped while waiting: one more stall cycle, then RUN, no error
        mem_ready = 0;
        tick();
        mem_req = 0;
        #1;
        chk("req_drop_ctl", 32'(ctl_bus()), 32'(C_MEM));
        tick();
        chk("req_drop_after_ctl", 32'(ctl_bus()), 32'(C_NONE));
        chk("req_drop_err", 32'(mem_err), 0);
        chk("req_drop_cnt", 32'(mem_wait_cnt), 8);

        // Timeout: never ready
        mem_req = 1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("timeout_7_err", 32'(mem_err), 0);
        tick();
        chk("timeout_8_err", 32'(mem_err), 1);
        chk("timeout_ctl", 32'(ctl_bus()), 32'(C_MEM));
        chk("mem_wait_cnt_sat", 32'(mem_wait_cnt), 15);
        tick();
        chk("timeout_sticky", 32'(mem_err), 1);

        // Asynchronous reset mid-wait, with mem_req still held
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ctl", 32'(ctl_bus()), 32'(C_NONE));
        chk("async_rst_err", 32'(mem_err), 0);
        chk("async_rst_cnts", {20'd0, stall_cnt, mem_wait_cnt, flush_cnt}, 0);
        mem_req = 0;
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ctl", 32'(ctl_bus()), 32'(C_NONE));

        // Stall counter saturation
        exe_dest = 4'd3; exe_wb_en = 1; id_src_1 = 4'd3; id_uses_src_1 = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("stall_sat", 32'(stall_cnt), 15);
        chk("stall_sat_ctl", 32'(ctl_bus()), 32'(C_HAZ));
        chk("sat_flush_cnt", 32'(flush_cnt), 0);
        chk("sat_mem_cnt", 32'(mem_wait_cnt), 0);
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
